// File: rtl/zellers_congruence_core.sv
// zellers_congruence_core: 2-stage pipelined BCD date -> Zeller weekday (0=Sat..6=Fri, 7=invalid).
// Define ZC_DATE_VALID_EN to also reject days beyond the month length (leap when YY%4==0).
module zellers_congruence_core #(
  parameter int CENTURY = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] year,
  input  logic [7:0] month,
  input  logic [7:0] day,
  output logic [2:0] day_of_week,
  output logic       date_err
);
  localparam logic [9:0] J_CUR = 10'(CENTURY / 4 + 5 * CENTURY);
  localparam logic [9:0] J_PRV = 10'((CENTURY - 1) / 4 + 5 * (CENTURY - 1));

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return {3'd0, b[7:4]} * 7'd10 + {3'd0, b[3:0]};
  endfunction

  // 8 == 1 (mod 7), so summing octal digits preserves the residue
  function automatic logic [2:0] mod7(input logic [9:0] a);
    logic [4:0] s;
    logic [3:0] t;
    s = {4'd0, a[9]} + {2'd0, a[8:6]} + {2'd0, a[5:3]} + {2'd0, a[2:0]};
    t = {2'd0, s[4:3]} + {1'd0, s[2:0]};
    return (t >= 4'd7) ? 3'(t - 4'd7) : t[2:0];
  endfunction

  logic [6:0] y_bin, m_bin, d_bin;
  logic       nib_ok, early, valid;
  logic [4:0] q_d, q_q;
  logic [3:0] m_d, m_q;
  logic [6:0] k_d, k_q;
  logic       jp_d, jp_q, err1_d, err1_q;
  logic [5:0] f;
  logic [9:0] sum;
  logic [2:0] dow_d, dow_q;
  logic       err2_d, err2_q;
`ifdef ZC_DATE_VALID_EN
  logic [6:0] dim;
`endif

  always_comb begin
    y_bin  = bcd2bin(year);
    m_bin  = bcd2bin(month);
    d_bin  = bcd2bin(day);
    nib_ok = year[7:4] <= 4'd9 && year[3:0] <= 4'd9 && month[7:4] <= 4'd9 &&
             month[3:0] <= 4'd9 && day[7:4] <= 4'd9 && day[3:0] <= 4'd9;
    valid  = nib_ok && m_bin >= 7'd1 && m_bin <= 7'd12 && d_bin >= 7'd1 && d_bin <= 7'd31;
`ifdef ZC_DATE_VALID_EN
    dim    = (m_bin == 7'd2) ? ((y_bin[1:0] == 2'd0) ? 7'd29 : 7'd28) :
             (m_bin == 7'd4 || m_bin == 7'd6 || m_bin == 7'd9 || m_bin == 7'd11) ? 7'd30 : 7'd31;
    valid  = valid && d_bin <= dim;
`endif
    early  = m_bin <= 7'd2;
    m_d    = early ? m_bin[3:0] + 4'd12 : m_bin[3:0];
    k_d    = !early ? y_bin : (y_bin == 7'd0) ? 7'd99 : y_bin - 7'd1;
    jp_d   = early && y_bin == 7'd0;
    q_d    = d_bin[4:0];
    err1_d = !valid;
  end

  // floor(13*(m+1)/5) for the shifted month 3..14
  always_comb begin
    case (m_q)
      4'd3:    f = 6'd10;
      4'd4:    f = 6'd13;
      4'd5:    f = 6'd15;
      4'd6:    f = 6'd18;
      4'd7:    f = 6'd20;
      4'd8:    f = 6'd23;
      4'd9:    f = 6'd26;
      4'd10:   f = 6'd28;
      4'd11:   f = 6'd31;
      4'd12:   f = 6'd33;
      4'd13:   f = 6'd36;
      4'd14:   f = 6'd39;
      default: f = 6'd0;
    endcase
  end

  always_comb begin
    sum    = {5'd0, q_q} + {4'd0, f} + {3'd0, k_q} + {5'd0, k_q[6:2]} + (jp_q ? J_PRV : J_CUR);
    dow_d  = err1_q ? 3'd7 : mod7(sum);
    err2_d = err1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      m_q    <= '0;
      k_q    <= '0;
      jp_q   <= 1'b0;
      err1_q <= 1'b0;
      dow_q  <= '0;
      err2_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      m_q    <= m_d;
      k_q    <= k_d;
      jp_q   <= jp_d;
      err1_q <= err1_d;
      dow_q  <= dow_d;
      err2_q <= err2_d;
    end
  end

  assign day_of_week = dow_q;
  assign date_err    = err2_q;
endmodule

// File: tb/tb_zellers_congruence_core.sv
// tb_zellers_congruence_core: directed streaming vectors with hand-computed weekdays.
module tb_zellers_congruence_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] year = '0, month = '0, day = '0;
  logic [2:0] day_of_week;
  logic       date_err;
  int         n_vec = 0, n_err = 0;

  typedef struct packed {
    logic [7:0] y, m, d;
    logic [2:0] h;
    logic       e;
  } vec_t;
  vec_t v[$];

  zellers_congruence_core dut (
    .clk(clk), .rst_n(rst_n), .year(year), .month(month), .day(day),
    .day_of_week(day_of_week), .date_err(date_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] y, m, d, input logic [2:0] h, input logic e);
    v.push_back('{y: y, m: m, d: d, h: h, e: e});
  endtask

  initial begin
    add(8'h24, 8'h05, 8'h01, 3'd4, 1'b0);
    // day ramp 01..10 by binary +1; Wed May 1 2024 => h = (3+q) mod 7
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] dd;
      dd = 8'(i);
      if (i >= 10 && i <= 15) add(8'h24, 8'h05, dd, 3'd7, 1'b1);
      else if (i == 16)       add(8'h24, 8'h05, dd, 3'd6, 1'b0);
      else                    add(8'h24, 8'h05, dd, 3'((3 + i) % 7), 1'b0);
    end
    add(8'h00, 8'h01, 8'h01, 3'd0, 1'b0);
    add(8'h24, 8'h02, 8'h29, 3'd5, 1'b0);
    add(8'h24, 8'h05, 8'h31, 3'd6, 1'b0);
    add(8'h24, 8'h13, 8'h01, 3'd7, 1'b1);
    add(8'h24, 8'h05, 8'h00, 3'd7, 1'b1);
    add(8'h9A, 8'h05, 8'h01, 3'd7, 1'b1);
    add(8'h24, 8'h00, 8'h01, 3'd7, 1'b1);
    add(8'h00, 8'h02, 8'h29, 3'd3, 1'b0);
    add(8'h99, 8'h12, 8'h31, 3'd5, 1'b0);
`ifdef ZC_DATE_VALID_EN
    add(8'h23, 8'h02, 8'h29, 3'd7, 1'b1);
    add(8'h24, 8'h04, 8'h31, 3'd7, 1'b1);
`else
    add(8'h23, 8'h02, 8'h29, 3'd4, 1'b0);
    add(8'h24, 8'h04, 8'h31, 3'd4, 1'b0);
`endif
    add(8'h24, 8'h05, 8'h01, 3'd4, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_dow", {5'd0, day_of_week}, 8'd0);
    check("reset_err", {7'd0, date_err}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < v.size() + 2; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) begin
        check($sformatf("v%0d_dow", i - 2), {5'd0, day_of_week}, {5'd0, v[i-2].h});
        check($sformatf("v%0d_err", i - 2), {7'd0, date_err}, {7'd0, v[i-2].e});
      end
      if (i < v.size()) begin
        year = v[i].y; month = v[i].m; day = v[i].d;
      end
    end

    // mid-stream reset with a constant date, then release
    year = 8'h24; month = 8'h05; day = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_dow", {5'd0, day_of_week}, 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_dow", {5'd0, day_of_week}, 8'd0);
    check("rst_async_err", {7'd0, date_err}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_dow", {5'd0, day_of_week}, 8'd4);
    check("post_rst_err", {7'd0, date_err}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
